// File: rtl/datapath_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset datapath: opcode/funct
// encodings, FSM states, ALU operation codes and the small decode helpers.
package datapath_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        TRAP
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    // True when the instruction word belongs to the supported subset.
    function automatic logic is_legal(input logic [31:0] ir);
        logic ok;
        ok = 1'b0;
        case (ir[31:26])
            OP_RTYPE: begin
                case (ir[5:0])
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
                    default: ok = 1'b0;
                endcase
            end
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // R-type funct field to ALU operation.
    function automatic alu_op_t alu_ctrl(input logic [5:0] funct);
        alu_op_t op;
        case (funct)
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            FN_OR:   op = ALU_OR;
            FN_SLT:  op = ALU_SLT;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu.sv
// 32-bit ALU shared by PC increment, branch target and execute.
module alu
    import datapath_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  alu_op_t     op_i,
    output logic [31:0] y_o,
    output logic        zero_o
);

    // Result select; arithmetic wraps, slt compares signed.
    always_comb begin
        y_o = '0;
        case (op_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_SLT: y_o = {31'b0, $signed(a_i) < $signed(b_i)};
            default: y_o = '0;
        endcase
    end

    assign zero_o = (y_o == 32'd0);

endmodule

// File: rtl/regfile_param.sv
// NREG x 32 register file: two combinational read ports, one synchronous
// write port. Register 0 always reads zero and ignores writes. No reset.
module regfile_param #(
    parameter int NREG = 32
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [$clog2(NREG)-1:0] waddr_i,
    input  logic [31:0]             wdata_i,
    input  logic [$clog2(NREG)-1:0] raddr_a_i,
    output logic [31:0]             rdata_a_o,
    input  logic [$clog2(NREG)-1:0] raddr_b_i,
    output logic [31:0]             rdata_b_o
);

    logic [31:0] regs_q [NREG];

    // Write port; r0 is never stored so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? 32'd0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? 32'd0 : regs_q[raddr_b_i];

endmodule

// File: rtl/datapath_multiciclo.sv
// Multi-cycle MIPS-subset datapath. One FSM walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB; a single ALU serves PC+4, branch target and
// execute. Memories use req/ack handshakes and may insert wait states.
module datapath_multiciclo
    import datapath_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                NREG     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic [ADDR_W-1:0] pc_out,
    output logic              retire,
    output logic [31:0]       wb_data,
    output logic              halted
);

    localparam int RW = $clog2(NREG);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       aluout_q, aluout_d;
    logic [31:0]       mdr_q, mdr_d;

    logic              imem_req_c, dmem_req_c, rf_we_c, retire_c, halted_c;
    logic [31:0]       wb_c;

    // Instruction fields and decode
    logic [5:0]  opcode, funct;
    logic [31:0] sext_imm, pc32, jump_tgt;
    logic        is_r, is_lw, is_sw, is_beq, is_j;

    assign opcode   = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
    assign pc32     = 32'(pc_q);
    // pc_q already holds PC+4 once the fetch has completed
    assign jump_tgt = {pc32[31:28], ir_q[25:0], 2'b00};

    assign is_r   = (opcode == OP_RTYPE);
    assign is_lw  = (opcode == OP_LW);
    assign is_sw  = (opcode == OP_SW);
    assign is_beq = (opcode == OP_BEQ);
    assign is_j   = (opcode == OP_J);

    // Register file
    logic [RW-1:0] rf_waddr;
    logic [31:0]   rf_wdata, rf_a, rf_b;

    assign rf_waddr = is_r ? ir_q[11 +: RW] : ir_q[16 +: RW];
    assign rf_wdata = is_lw ? mdr_q : aluout_q;

    regfile_param #(.NREG(NREG)) u_rf (
        .clk_i     (CLK),
        .we_i      (rf_we_c & ~RST),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata),
        .raddr_a_i (ir_q[21 +: RW]),
        .rdata_a_o (rf_a),
        .raddr_b_i (ir_q[16 +: RW]),
        .rdata_b_o (rf_b)
    );

    // Shared ALU
    logic [31:0] alu_a, alu_b, alu_y;
    alu_op_t     alu_op;
    logic        alu_zero;

    alu u_alu (
        .a_i    (alu_a),
        .b_i    (alu_b),
        .op_i   (alu_op),
        .y_o    (alu_y),
        .zero_o (alu_zero)
    );

    // ALU operand select: PC+4 in FETCH, branch target in DECODE, execute in EXEC
    always_comb begin
        alu_a  = pc32;
        alu_b  = 32'd4;
        alu_op = ALU_ADD;
        case (state_q)
            DECODE: alu_b = sext_imm << 2;
            EXEC: begin
                alu_a = a_q;
                if (is_r) begin
                    alu_b  = b_q;
                    alu_op = alu_ctrl(funct);
                end else if (is_beq) begin
                    alu_b  = b_q;
                    alu_op = ALU_SUB;
                end else begin
                    alu_b  = sext_imm;
                end
            end
            default: ;
        endcase
    end

    // Next-state and control outputs
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        aluout_d   = aluout_q;
        mdr_d      = mdr_q;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        rf_we_c    = 1'b0;
        retire_c   = 1'b0;
        wb_c       = '0;
        halted_c   = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_data;
                    pc_d    = ADDR_W'(alu_y);
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d      = rf_a;
                b_d      = rf_b;
                aluout_d = alu_y;
                if (!is_legal(ir_q)) begin
                    state_d = TRAP;
                end else if (is_j) begin
                    pc_d     = ADDR_W'(jump_tgt);
                    retire_c = 1'b1;
                    state_d  = FETCH;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (is_beq) begin
                    if (alu_zero) pc_d = ADDR_W'(aluout_q);
                    retire_c = 1'b1;
                    state_d  = FETCH;
                end else if (is_lw || is_sw) begin
                    // misaligned accesses trap before any request goes out
                    if (alu_y[1:0] != 2'b00) begin
                        state_d = TRAP;
                    end else begin
                        aluout_d = alu_y;
                        state_d  = MEM;
                    end
                end else begin
                    aluout_d = alu_y;
                    state_d  = WB;
                end
            end
            MEM: begin
                dmem_req_c = 1'b1;
                if (dmem_ack) begin
                    if (is_sw) begin
                        retire_c = 1'b1;
                        state_d  = FETCH;
                    end else begin
                        mdr_d   = dmem_rdata;
                        state_d = WB;
                    end
                end
            end
            WB: begin
                rf_we_c  = 1'b1;
                retire_c = 1'b1;
                wb_c     = rf_wdata;
                state_d  = FETCH;
            end
            TRAP: halted_c = 1'b1;
            default: state_d = FETCH;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
            mdr_q    <= mdr_d;
        end
    end

    // Outputs are forced quiet while reset is held
    assign imem_req   = imem_req_c & ~RST;
    assign imem_addr  = pc_q;
    assign dmem_req   = dmem_req_c & ~RST;
    assign dmem_we    = dmem_req & is_sw;
    assign dmem_addr  = ADDR_W'(aluout_q);
    assign dmem_wdata = b_q;
    assign pc_out     = pc_q;
    assign retire     = retire_c & ~RST;
    assign wb_data    = RST ? 32'd0 : wb_c;
    assign halted     = halted_c & ~RST;

    // shamt and, for small NREG, upper index bits are intentionally ignored
    logic unused_ir;
    assign unused_ir = ^ir_q;

endmodule

// File: tb/tb_datapath_multiciclo.sv
// Self-checking bench: small programs run against behavioural memories with
// programmable wait states; a scoreboard of expected retires is checked by a
// negedge monitor, and each test task checks its own end conditions.
module tb_datapath_multiciclo;

    localparam int          ADDR_W = 32;
    localparam int          NREG   = 8;
    localparam logic [31:0] BASE   = 32'h100;
    localparam logic [31:0] TRAPW  = 32'hFC00_0000;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
    logic [ADDR_W-1:0] imem_addr, dmem_addr, pc_out;
    logic [31:0]       imem_data, dmem_wdata, dmem_rdata, wb_data;
    logic              retire, halted;

    always #5 CLK = ~CLK;

    datapath_multiciclo #(.ADDR_W(ADDR_W), .NREG(NREG), .RESET_PC(BASE)) dut (
        .CLK(CLK), .RST(RST),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .pc_out(pc_out), .retire(retire), .wb_data(wb_data), .halted(halted)
    );

    // ---------------- memory models ----------------
    logic [31:0] imem_arr [0:63];
    logic [31:0] dmem_arr [0:15];
    int          iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
    bit          dspur = 1'b0;
    logic [31:0] st_addr = '0, st_data = '0;
    logic [31:0] ioff;

    assign ioff       = imem_addr - BASE;
    assign imem_data  = (imem_addr >= BASE && imem_addr < BASE + 32'h100) ? imem_arr[ioff[7:2]] : TRAPW;
    assign imem_ack   = imem_req && (icnt >= iwait);
    assign dmem_ack   = dspur || (dmem_req && (dcnt >= dwait));
    assign dmem_rdata = dmem_arr[dmem_addr[5:2]];

    always @(posedge CLK) begin
        icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
        dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
        if (dmem_req && dmem_we && dmem_ack) begin
            dmem_arr[dmem_addr[5:2]] <= dmem_wdata;
            st_addr <= dmem_addr;
            st_data <= dmem_wdata;
        end
    end

    // ---------------- scoreboard + monitor ----------------
    typedef struct {
        logic [31:0] wb;
        logic [31:0] npc;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_cmp = 0, n_err = 0;
    int          cnt = 0, ndreq = 0, nireq = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_pc = '0;
    logic        p_ireq = 1'b0, p_iack = 1'b0, p_dreq = 1'b0, p_dack = 1'b0, p_dwe = 1'b0;
    logic [31:0] p_iaddr = '0, p_daddr = '0, p_dwdata = '0;

    always @(negedge CLK) begin
        if (pend) begin
            n_cmp++;
            if (pc_out !== pend_pc) begin
                n_err++;
                $display("FAIL next_pc: got %h want %h", pc_out, pend_pc);
            end
            pend = 1'b0;
        end
        if (!RST && p_ireq && !p_iack) begin
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== p_iaddr) begin
                n_err++;
                $display("FAIL imem_hold: req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, p_iaddr);
            end
        end
        if (!RST && p_dreq && !p_dack) begin
            n_cmp++;
            if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, p_dwe, p_daddr, p_dwdata}) begin
                n_err++;
                $display("FAIL dmem_hold: req=%b we=%b addr=%h wdata=%h want 1 %b %h %h",
                         dmem_req, dmem_we, dmem_addr, dmem_wdata, p_dwe, p_daddr, p_dwdata);
            end
        end
        p_ireq = imem_req; p_iack = imem_ack; p_iaddr = imem_addr;
        p_dreq = dmem_req; p_dack = dmem_ack; p_dwe = dmem_we;
        p_daddr = dmem_addr; p_dwdata = dmem_wdata;
        if (dmem_req) ndreq++;
        if (imem_req) nireq++;
        if (RST) begin
            cnt = 0;
        end else begin
            cnt++;
            if (!retire) begin
                n_cmp++;
                if (wb_data !== 32'd0) begin
                    n_err++;
                    $display("FAIL wb_idle: got %h want 0", wb_data);
                end
            end else begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_retire: got retire at pc %h want none", pc_out);
                end else begin
                    e = sb.pop_front();
                    if (wb_data !== e.wb || cnt != e.cyc) begin
                        n_err++;
                        $display("FAIL retire: wb=%h cycles=%0d want wb=%h cycles=%0d",
                                 wb_data, cnt, e.wb, e.cyc);
                    end
                    pend    = 1'b1;
                    pend_pc = e.npc;
                end
                cnt = 0;
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] tgt);
        return {6'h02, tgt[27:2]};
    endfunction

    task automatic rst_assert();
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1;
        for (int i = 0; i < 64; i++) imem_arr[i] = TRAPW;
        sb.delete();
    endtask

    task automatic rst_release();
        @(posedge CLK); #1 RST = 1'b0;
        #1;
    endtask

    task automatic sb_push(input logic [31:0] wb, input logic [31:0] npc, input int cyc);
        exp_t x;
        x.wb = wb; x.npc = npc; x.cyc = cyc;
        sb.push_back(x);
    endtask

    task automatic run(input string name, input int budget);
        int t;
        t = 0;
        while ((sb.size() != 0 || pend) && t < budget) begin
            @(posedge CLK);
            t++;
        end
        #1;
        n_cmp++;
        if (sb.size() != 0 || pend) begin
            n_err++;
            $display("FAIL %s_timeout: %0d retires outstanding want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_halt(input string name, input int budget);
        int t;
        t = 0;
        while (!halted && t < budget) begin
            @(posedge CLK); #1;
            t++;
        end
        n_cmp++;
        if (halted !== 1'b1) begin
            n_err++;
            $display("FAIL %s_halt: halted=%b want 1", name, halted);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_assert();
        n_cmp++;
        if ({imem_req, dmem_req, retire, halted, wb_data} !== 36'd0) begin
            n_err++;
            $display("FAIL reset_quiet: req=%b dreq=%b ret=%b halt=%b wb=%h want all 0",
                     imem_req, dmem_req, retire, halted, wb_data);
        end
        rst_release();
        n_cmp++;
        if (imem_addr !== BASE || imem_req !== 1'b1 || retire !== 1'b0 || halted !== 1'b0 || pc_out !== BASE) begin
            n_err++;
            $display("FAIL reset_release: addr=%h req=%b ret=%b halt=%b want addr=%h req=1 ret=0 halt=0",
                     imem_addr, imem_req, retire, halted, BASE);
        end
        wait_halt("reset", 20);
    endtask

    task automatic test_alu();
        logic [31:0] w [9];
        logic [31:0] x [8];
        rst_assert();
        iwait = 0; dwait = 0;
        w[0] = enc_i(6'h08, 1, 0, 5);
        w[1] = enc_i(6'h08, 2, 0, -3);
        w[2] = enc_r(3, 1, 2, 6'h20);
        w[3] = enc_r(5, 1, 2, 6'h22);
        w[4] = enc_r(6, 1, 2, 6'h24);
        w[5] = enc_r(7, 1, 2, 6'h25);
        w[6] = enc_r(4, 2, 1, 6'h2A);
        w[7] = enc_r(4, 1, 2, 6'h2A);
        w[8] = TRAPW;
        x = '{32'd5, 32'hFFFF_FFFD, 32'd2, 32'd8, 32'd5, 32'hFFFF_FFFD, 32'd1, 32'd0};
        for (int i = 0; i < 9; i++) imem_arr[i] = w[i];
        for (int i = 0; i < 8; i++) sb_push(x[i], BASE + 32'(4 * (i + 1)), 4);
        rst_release();
        run("alu", 200);
        wait_halt("alu", 20);
    endtask

    task automatic test_mem();
        int n0;
        rst_assert();
        iwait = 0; dwait = 3;
        for (int i = 0; i < 16; i++) dmem_arr[i] = 32'hDEAD_BEEF;
        imem_arr[0] = enc_i(6'h08, 1, 0, 5);
        imem_arr[1] = enc_i(6'h08, 2, 0, -3);
        imem_arr[2] = enc_r(3, 1, 2, 6'h20);
        imem_arr[3] = enc_i(6'h2B, 3, 0, 8);
        imem_arr[4] = enc_i(6'h23, 4, 0, 8);
        imem_arr[5] = enc_r(5, 4, 1, 6'h20);
        sb_push(32'd5, 32'h104, 4);
        sb_push(32'hFFFF_FFFD, 32'h108, 4);
        sb_push(32'd2, 32'h10C, 4);
        sb_push(32'd0, 32'h110, 7);
        sb_push(32'd2, 32'h114, 8);
        sb_push(32'd7, 32'h118, 4);
        n0 = ndreq;
        rst_release();
        run("mem", 300);
        n_cmp++;
        if (st_addr !== 32'd8 || st_data !== 32'd2 || dmem_arr[2] !== 32'd2) begin
            n_err++;
            $display("FAIL mem_store: addr=%h data=%h mem=%h want 8 2 2", st_addr, st_data, dmem_arr[2]);
        end
        n_cmp++;
        if (ndreq - n0 != 8) begin
            n_err++;
            $display("FAIL mem_req_cycles: got %0d want 8", ndreq - n0);
        end
        wait_halt("mem", 20);
    endtask

    task automatic test_branch();
        rst_assert();
        iwait = 0; dwait = 0;
        imem_arr[0] = enc_i(6'h08, 1, 0, 5);
        imem_arr[1] = enc_i(6'h08, 2, 0, 7);
        imem_arr[2] = enc_i(6'h04, 2, 1, 5);     // not taken
        imem_arr[3] = enc_j(32'h118);
        imem_arr[6] = enc_i(6'h04, 1, 1, 1);     // taken, skips 0x11C
        imem_arr[8] = enc_i(6'h04, 1, 1, -1);    // branches to itself
        sb_push(32'd5, 32'h104, 4);
        sb_push(32'd7, 32'h108, 4);
        sb_push(32'd0, 32'h10C, 3);
        sb_push(32'd0, 32'h118, 2);
        sb_push(32'd0, 32'h120, 3);
        sb_push(32'd0, 32'h120, 3);
        sb_push(32'd0, 32'h120, 3);
        rst_release();
        run("branch", 200);
    endtask

    task automatic test_trap();
        int n0;
        // misaligned load
        rst_assert();
        iwait = 0; dwait = 0;
        imem_arr[0] = enc_i(6'h08, 1, 0, 6);
        imem_arr[1] = enc_i(6'h23, 2, 1, 0);
        sb_push(32'd6, 32'h104, 4);
        n0 = ndreq;
        rst_release();
        run("trap_align", 100);
        wait_halt("trap_align", 20);
        n_cmp++;
        if (ndreq != n0) begin
            n_err++;
            $display("FAIL trap_align_dreq: got %0d request cycles want 0", ndreq - n0);
        end
        n0 = nireq;
        repeat (5) @(posedge CLK);
        #1;
        n_cmp++;
        if (nireq != n0 || halted !== 1'b1) begin
            n_err++;
            $display("FAIL trap_absorb: ireq cycles=%0d halted=%b want 0 1", nireq - n0, halted);
        end
        // bad opcode 0x3F, then recovery by reset
        rst_assert();
        n_cmp++;
        if (halted !== 1'b0) begin
            n_err++;
            $display("FAIL trap_reset: halted=%b want 0", halted);
        end
        rst_release();
        n_cmp++;
        if (imem_addr !== BASE || imem_req !== 1'b1 || halted !== 1'b0) begin
            n_err++;
            $display("FAIL trap_recover: addr=%h req=%b halt=%b want %h 1 0", imem_addr, imem_req, halted, BASE);
        end
        wait_halt("trap_op", 10);
        // bad funct 0x21
        rst_assert();
        imem_arr[0] = enc_r(3, 1, 2, 6'h21);
        rst_release();
        wait_halt("trap_funct", 10);
    endtask

    task automatic test_nreg();
        logic [31:0] x [7];
        rst_assert();
        iwait = 0; dwait = 0;
        imem_arr[0] = enc_i(6'h08, 1, 0, 5);
        imem_arr[1] = enc_i(6'h08, 2, 0, -3);
        imem_arr[2] = enc_r(9, 1, 2, 6'h20);     // r9 aliases r1
        imem_arr[3] = enc_i(6'h08, 0, 0, 7);     // discarded
        imem_arr[4] = enc_r(3, 1, 0, 6'h20);
        imem_arr[5] = enc_i(6'h08, 8, 0, 9);     // r8 aliases r0, discarded
        imem_arr[6] = enc_r(5, 8, 1, 6'h20);
        x = '{32'd5, 32'hFFFF_FFFD, 32'd2, 32'd7, 32'd2, 32'd9, 32'd2};
        for (int i = 0; i < 7; i++) sb_push(x[i], BASE + 32'(4 * (i + 1)), 4);
        rst_release();
        run("nreg", 200);
        wait_halt("nreg", 20);
    endtask

    task automatic test_back_to_back();
        rst_assert();
        iwait = 2; dwait = 1;
        imem_arr[0] = enc_i(6'h08, 1, 0, 12);
        imem_arr[1] = enc_i(6'h2B, 1, 0, 4);
        imem_arr[2] = enc_i(6'h23, 2, 0, 4);
        imem_arr[3] = enc_i(6'h04, 1, 2, 1);
        imem_arr[5] = enc_j(32'h11C);
        imem_arr[7] = enc_i(6'h08, 3, 2, -12);
        sb_push(32'd12, 32'h104, 6);
        sb_push(32'd0, 32'h108, 7);
        sb_push(32'd12, 32'h10C, 8);
        sb_push(32'd0, 32'h114, 5);
        sb_push(32'd0, 32'h11C, 4);
        sb_push(32'd0, 32'h120, 6);
        rst_release();
        run("b2b", 300);
        wait_halt("b2b", 30);
        iwait = 0; dwait = 0;
    endtask

    task automatic test_spurious();
        rst_assert();
        dspur = 1'b1;
        dmem_arr[0] = 32'h55;
        imem_arr[0] = enc_i(6'h08, 1, 0, 3);
        imem_arr[1] = enc_i(6'h23, 2, 0, 0);
        imem_arr[2] = enc_r(3, 2, 1, 6'h20);
        sb_push(32'd3, 32'h104, 4);
        sb_push(32'h55, 32'h108, 5);
        sb_push(32'h58, 32'h10C, 4);
        rst_release();
        run("spur", 100);
        wait_halt("spur", 20);
        dspur = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) imem_arr[i] = TRAPW;
        for (int i = 0; i < 16; i++) dmem_arr[i] = '0;
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_trap();
        test_nreg();
        test_back_to_back();
        test_spurious();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d compares so far", n_cmp);
        $fatal(1);
    end

endmodule

// File: doc/datapath_multiciclo.md
Name: datapath_multiciclo

Overview:
- Multi-cycle MIPS-subset datapath; successor to the single-cycle R-type datapath.
- Sequences each instruction through an internal FSM (fetch/decode/execute/memory/writeback) and shares one ALU across PC increment, branch target and execute.
- Talks to external instruction and data memories over valid/ready-style handshakes that tolerate wait states.
- Sits between the top-level SoC and the memory models; exposes retire/debug signals for the bench.

Parameters:
- ADDR_W, 32, width of PC and memory addresses; byte addresses, word-aligned.
- NREG, 32, register count, one of 8/16/32; register index = low log2(NREG) bits of instruction field.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address (= PC).
- imem_ack  in  1  fetch data valid this cycle.
- imem_data  in  32  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  ADDR_W  ALU result.
- dmem_wdata  out  32  rt register value.
- dmem_ack  in  1  access complete; load data valid.
- dmem_rdata  in  32  load data.
- pc_out  out  ADDR_W  current PC.
- retire  out  1  one-cycle pulse when an instruction completes.
- wb_data  out  32  value written to the register file on the retire cycle, else 0.
- halted  out  1  high in TRAP state.

Behaviour:
- Instructions: R-type (funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A); lw 0x23; sw 0x2B; beq 0x04; addi 0x08; j 0x02. Any other opcode or funct -> TRAP.
- Immediate is sign-extended. Branch target = PC+4 + (sext(imm)<<2). Jump target = {PC+4[ADDR_W-1:28], imm26, 2'b00}, truncated to ADDR_W.
- Arithmetic is 32-bit wrap-around with no overflow trap. slt is signed.
- Register 0 reads 0 and writes to it are discarded. The register file has no reset; its contents after reset are undefined except r0.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, TRAP.
  - FETCH: imem_req=1 and is held, with imem_addr stable, until imem_ack. On ack, latch IR and PC<=PC+4, then go to DECODE.
  - DECODE: read rs/rt into A/B; compute branch target into ALUOut. Go to TRAP if illegal; for j, load PC and retire -> FETCH; otherwise -> EXEC.
  - EXEC: R/addi compute ALUOut -> WB. lw/sw compute address -> MEM. beq: if A==B then PC<=target; retire -> FETCH.
  - MEM: dmem_req=1 and is held, with addr/we/wdata stable, until dmem_ack. sw: retire -> FETCH. lw: latch MDR -> WB.
  - WB: write rd (R) or rt (lw/addi); retire=1 and wb_data=written value -> FETCH.
  - TRAP: absorbing; halted=1, no requests issued; exited only by RST.
- Zero-wait cycle counts per instruction: j 2, beq 3, R/addi 4, sw 4, lw 5. Each wait cycle adds one.
- Address alignment: dmem_addr bits[1:0] != 0 -> TRAP from EXEC, with no request issued.
- Reset, including mid-access: next state FETCH, PC=RESET_PC, all req/we/retire/halted/wb_data=0, IR=0. An outstanding ack arriving during or after reset is ignored.
- An ack received while no request is outstanding is ignored.
- Exactly one retire per completed instruction; no retire on TRAP.

Decomposition:
- Shared package datapath_pkg: opcode and funct constants, FSM state enum, ALU op encoding (reused by the existing ALU_Control).
- One sub-module, regfile_param (NREG x 32, 2 async read ports, 1 sync write port, r0 hardwired). The existing ALU is instantiated unchanged.

Test Plan:
- Reset: RST high 2 cycles, RESET_PC=0x100 -> imem_addr=0x100, imem_req=1 on the first cycle after release; retire=0, halted=0.
- addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2 with zero-wait memories -> retire pulses with wb_data 5, 0xFFFFFFFD, 2; total 12 cycles.
- sw r3,8(r0) then lw r4,8(r0), with dmem_ack delayed 3 cycles -> dmem_we=1, addr=8, wdata=2, signals stable throughout the wait; lw retires wb_data=2 after 5+3 cycles.
- beq r1,r1,-1 -> PC returns to the beq address; beq r1,r2 not taken -> PC+4; 3 cycles each.
- Opcode 0x3F, or lw with address 0x6 -> halted=1, no further imem_req; RST recovers to RESET_PC.
- NREG=8: add r9,r1,r2 writes r1; writes to r0 leave it reading 0.
